updown_counter_ctl: RTL
=======================

Name: updown_counter_ctl

Overview:
- Parametrised up/down counter: the next generation of the team's basic up/down counter.
- Adds enable, a programmable prescaler, parallel load, synchronous clear and a programmable terminal value (limit).
- Three boundary modes: wrap, saturate, one-shot.
- Provides a terminal-count pulse and a sticky overflow flag.
- Intended as the general timer/event-counter primitive for the lab designs.

Parameters:
- CW, 8, counter width in bits.
- PSC_W, 4, prescaler width in bits.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- resetn, in, 1, asynchronous, active-low reset.
- clr, in, 1, synchronous clear.
- load, in, 1, synchronous parallel load of load_val.
- load_val, in, CW, value loaded into the counter.
- en, in, 1, count enable.
- dir, in, 1, 1 = count up, 0 = count down.
- limit, in, CW, terminal value for up counting and reload value for down wrap.
- mode, in, 2, 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- psc, in, PSC_W, a step occurs every psc+1 enabled cycles.
- ovf_clr, in, 1, clears the ovf flag.
- c_out, out, CW, current count.
- tc, out, 1, one-cycle terminal-count pulse.
- ovf, out, 1, sticky boundary-event flag.
- running, out, 1, counter armed (steps permitted).

Behaviour:
- Reset (resetn=0, asynchronous):
  - c_out=0, tc=0, ovf=0, running=1.
  - Prescaler count p=0.
- Priority per cycle: clr > load > step.
  - clr: c_out=0, p=0, running=1, tc=0. ovf unaffected.
  - load: c_out=load_val, p=0, running=1, tc=0. load_val > limit is accepted as-is.
- Prescaler p (PSC_W bits):
  - Advances only when en=1 and running=1; holds otherwise.
  - tick = en & running & (p==psc).
  - On tick p returns to 0; otherwise p+1.
  - psc=0 gives a tick every enabled cycle.
  - psc changed mid-count: compare is against the live value. If p > psc, p counts up through wrap-around of PSC_W to 0, then compares normally.
- Step (on tick, no clr/load):
  - Up (dir=1): boundary when c_out >= limit; otherwise c_out+1.
  - Down (dir=0): boundary when c_out == 0; otherwise c_out-1. c_out > limit simply decrements.
- Boundary step actions:
  - wrap: up → 0; down → limit.
  - saturate: c_out holds.
  - one-shot: c_out holds and running←0. All further steps and prescaler frozen until clr or load.
- tc:
  - Registered: high for exactly one cycle, the cycle after the boundary step edge. It is concurrent with the post-boundary c_out.
  - In saturate mode, each further tick at the boundary pulses tc again.
- ovf:
  - Set on every boundary step.
  - Cleared by ovf_clr.
  - Set wins if ovf_clr coincides with a boundary step.
- Arithmetic: all count arithmetic is modulo 2^CW. limit=0, up, wrap: c_out stays 0 and tc pulses every tick.
- dir or mode change takes effect on the next tick; no state other than running is mode-dependent.
- Asynchronous reset mid-count returns all state to reset values immediately.

Test Plan:
- Reset, then en=1, dir=1, mode=00, limit=5, psc=0 → c_out 0,1,2,3,4,5,0; tc high in the cycle c_out shows 0 after 5; ovf=1.
- en=1, dir=0, mode=00, limit=9, from reset → c_out 0→9 on first tick with tc pulse; then 8,7,…
- psc=2, dir=1, limit=255 → c_out increments every 3rd cycle; en=0 for 4 cycles freezes c_out and p.
- mode=01, limit=3, dir=1 → c_out holds at 3; tc pulses on every subsequent tick; ovf_clr then clears ovf, which re-sets on the next tick.
- mode=10, limit=2 → c_out 0,1,2 then holds, running=0, no tc after the first; load=1, load_val=0 re-arms and counting resumes; same-cycle clr+load → c_out=0.
- Counting at c_out=7, assert resetn=0 between clock edges → c_out=0, tc=0, ovf=0, running=1 immediately; load_val=200 with limit=10, dir=1 → next tick boundary, c_out=0.

Source files
------------

// File: rtl/updown_counter_ctl.sv
// Prescaled up/down counter with load, clear, programmable limit and wrap/saturate/one-shot boundary modes.
// Outputs are registered; tc pulses the cycle after a boundary step, ovf is sticky until ovf_clr.
module updown_counter_ctl #(
  parameter int CW    = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load,
  input  logic [CW-1:0]    load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [CW-1:0]    limit,
  input  logic [1:0]       mode,
  input  logic [PSC_W-1:0] psc,
  input  logic             ovf_clr,
  output logic [CW-1:0]    c_out,
  output logic             tc,
  output logic             ovf,
  output logic             running
);

  localparam logic [1:0]       MODE_SAT   = 2'b01;
  localparam logic [1:0]       MODE_ONESH = 2'b10;
  localparam logic [CW-1:0]    CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PSC_ONE    = {{(PSC_W-1){1'b0}}, 1'b1};

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PSC_W-1:0] p_q, p_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             running_q, running_d;
  logic             tick;
  logic             at_bound;

  // Equality against the live psc: if psc drops below p, p rolls over through zero.
  assign tick     = en & running_q & (p_q == psc);
  assign at_bound = dir ? (cnt_q >= limit) : (cnt_q == '0);

  always_comb begin
    cnt_d     = cnt_q;
    p_d       = p_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q & ~ovf_clr;
    running_d = running_q;

    if (clr) begin
      cnt_d     = '0;
      p_d       = '0;
      running_d = 1'b1;
    end else if (load) begin
      cnt_d     = load_val;
      p_d       = '0;
      running_d = 1'b1;
    end else begin
      if (en && running_q) begin
        p_d = tick ? '0 : p_q + PSC_ONE;
      end
      if (tick) begin
        if (at_bound) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          case (mode)
            MODE_SAT:   cnt_d = cnt_q;
            MODE_ONESH: running_d = 1'b0;
            default:    cnt_d = dir ? '0 : limit;
          endcase
        end else begin
          cnt_d = dir ? cnt_q + CNT_ONE : cnt_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      p_q       <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

  assign c_out   = cnt_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign running = running_q;

endmodule
